// File: rtl/display_fetch.sv
// display_fetch: per-line framebuffer fetch scheduler in the pixel clock domain.
// On a qualifying line_start it issues burst read requests for the next display
// line, steers returned beats into one half of a double line buffer, tracks the
// framebuffer line address across the frame, and pulses underrun when a new line
// is due while the previous fetch is still in flight.
module display_fetch #(
  parameter int CORDW     = 16,
  parameter int ADDRW     = 20,
  parameter int PIX_SHIFT = 2,
  parameter int BURST     = 16,
  parameter int LBAW      = 9
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    enable,
  input  logic [ADDRW-1:0]        base_addr,
  input  logic [ADDRW-1:0]        stride,
  input  logic [CORDW-1:0]        hres,
  input  logic signed [CORDW-1:0] vres,
  input  logic signed [CORDW-1:0] dy,
  input  logic                    line_start,
  input  logic                    frame_start,
  output logic                    req,
  output logic [ADDRW-1:0]        req_addr,
  output logic [7:0]              req_len,
  input  logic                    req_ack,
  input  logic                    rd_valid,
  output logic                    lb_we,
  output logic [LBAW-1:0]         lb_addr,
  output logic                    lb_sel,
  output logic                    busy,
  output logic                    underrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_r, state_n;

  logic [ADDRW-1:0]        line_addr_r, line_addr_n;
  logic [ADDRW-1:0]        fetch_addr_r, fetch_addr_n;
  logic [CORDW-1:0]        words_left_r, words_left_n;
  logic [8:0]              beat_r, beat_n;
  logic [LBAW-1:0]         lb_addr_r, lb_addr_n;
  logic                    lb_sel_r, lb_sel_n;
  logic                    req_r, busy_r, underrun_r;
  logic [ADDRW-1:0]        req_addr_r;
  logic [7:0]              req_len_r;
  logic                    underrun_n;
  logic                    qual_s;
  logic [CORDW-1:0]        wpl_s;
  logic signed [CORDW-1:0] vres_m2_s;
  logic signed [CORDW-1:0] neg_one_s;

  // Burst length for the next request: whole bursts until the line tail.
  function automatic logic [7:0] burst_len(input logic [CORDW-1:0] left);
    if (left >= CORDW'(BURST)) begin
      return 8'(BURST);
    end else begin
      return left[7:0];
    end
  endfunction

  assign wpl_s     = hres >> PIX_SHIFT;
  assign vres_m2_s = vres - CORDW'(2);
  assign neg_one_s = '1;
  // Target line dy+1 must lie inside the visible frame (dy from -1 to vres-2).
  assign qual_s    = line_start && enable && (dy >= neg_one_s) && (dy <= vres_m2_s);

  assign req      = req_r;
  assign req_addr = req_addr_r;
  assign req_len  = req_len_r;
  assign lb_addr  = lb_addr_r;
  assign lb_sel   = lb_sel_r;
  assign busy     = busy_r;
  assign underrun = underrun_r;

  // Next-state, line address tracking and line buffer write strobe.
  always_comb begin
    state_n      = state_r;
    line_addr_n  = line_addr_r;
    fetch_addr_n = fetch_addr_r;
    words_left_n = words_left_r;
    beat_n       = beat_r;
    lb_addr_n    = lb_addr_r;
    lb_sel_n     = lb_sel_r;
    lb_we        = 1'b0;
    underrun_n   = 1'b0;

    // frame_start wins over the per-line advance; dropped lines still advance.
    if (frame_start) begin
      line_addr_n = base_addr;
    end else if (qual_s) begin
      line_addr_n = line_addr_r + stride;
    end else begin
      line_addr_n = line_addr_r;
    end

    if (qual_s && (state_r != IDLE)) begin
      underrun_n = 1'b1;
    end else begin
      underrun_n = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (qual_s) begin
          fetch_addr_n = line_addr_r;
          words_left_n = wpl_s;
          lb_sel_n     = ~dy[0];
          lb_addr_n    = '0;
          if (wpl_s != '0) begin
            state_n = REQ;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        if (req_ack) begin
          beat_n       = {1'b0, req_len_r};
          fetch_addr_n = fetch_addr_r + ADDRW'(req_len_r);
          words_left_n = words_left_r - CORDW'(req_len_r);
          state_n      = WAIT;
        end else begin
          state_n = REQ;
        end
      end
      WAIT: begin
        if (rd_valid) begin
          lb_we     = 1'b1;
          lb_addr_n = lb_addr_r + LBAW'(1);
          beat_n    = beat_r - 9'd1;
          if (beat_r == 9'd1) begin
            if (words_left_r != '0) begin
              state_n = REQ;
            end else begin
              state_n = IDLE;
            end
          end else begin
            state_n = WAIT;
          end
        end else begin
          state_n = WAIT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; request outputs track the upcoming state.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_r      <= IDLE;
      line_addr_r  <= '0;
      fetch_addr_r <= '0;
      words_left_r <= '0;
      beat_r       <= 9'd0;
      lb_addr_r    <= '0;
      lb_sel_r     <= 1'b0;
      req_r        <= 1'b0;
      req_addr_r   <= '0;
      req_len_r    <= 8'd0;
      busy_r       <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      state_r      <= state_n;
      line_addr_r  <= line_addr_n;
      fetch_addr_r <= fetch_addr_n;
      words_left_r <= words_left_n;
      beat_r       <= beat_n;
      lb_addr_r    <= lb_addr_n;
      lb_sel_r     <= lb_sel_n;
      req_r        <= (state_n == REQ);
      req_addr_r   <= fetch_addr_n;
      req_len_r    <= burst_len(words_left_n);
      busy_r       <= (state_n != IDLE);
      underrun_r   <= underrun_n;
    end
  end

endmodule

// File: tb/tb_display_fetch.sv
// Directed bench for display_fetch: memory-port responder plus hand-computed
// burst addresses, lengths and line buffer addresses.
module tb_display_fetch;

  logic               clk_pix = 1'b0;
  logic               rst_pix;
  logic               enable;
  logic [19:0]        base_addr;
  logic [19:0]        stride;
  logic [15:0]        hres;
  logic signed [15:0] vres;
  logic signed [15:0] dy;
  logic               line_start;
  logic               frame_start;
  logic               req;
  logic [19:0]        req_addr;
  logic [7:0]         req_len;
  logic               req_ack;
  logic               rd_valid;
  logic               lb_we;
  logic [8:0]         lb_addr;
  logic               lb_sel;
  logic               busy;
  logic               underrun;

  int tests = 0;
  int fails = 0;

  display_fetch dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .enable(enable), .base_addr(base_addr),
    .stride(stride), .hres(hres), .vres(vres), .dy(dy), .line_start(line_start),
    .frame_start(frame_start), .req(req), .req_addr(req_addr), .req_len(req_len),
    .req_ack(req_ack), .rd_valid(rd_valid), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_sel(lb_sel), .busy(busy), .underrun(underrun)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic ls(input int v);
    line_start = 1'b1;
    dy = v[15:0];
    tick();
    line_start = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Answer one whole line: ack dly cycles after req, one beat every gap+1
  // cycles; optionally raise a line_start (dy=0) alongside beat number ur.
  task automatic serve(input logic [19:0] base, input int nw, input logic sel,
                       input int dly, input int gap, input int ur);
    int left;
    int w;
    int len;
    logic [19:0] a;
    left = nw;
    w = 0;
    a = base;
    while (left > 0) begin
      len = (left > 16) ? 16 : left;
      for (int t = 0; t < 200 && req !== 1'b1; t++) tick();
      chk("req", 32'(req), 32'd1);
      chk("req_addr", 32'(req_addr), 32'(a));
      chk("req_len", 32'(req_len), 32'(len));
      chk("lb_sel", 32'(lb_sel), 32'(sel));
      rd_valid = 1'b1;
      for (int d = 1; d < dly; d++) begin
        tick();
        chk("hold_req", 32'(req), 32'd1);
        chk("hold_addr", 32'(req_addr), 32'(a));
        chk("hold_len", 32'(req_len), 32'(len));
        chk("no_we_in_req", 32'(lb_we), 32'd0);
      end
      rd_valid = 1'b0;
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
      chk("req_drop", 32'(req), 32'd0);
      for (int b = 0; b < len; b++) begin
        rd_valid = 1'b1;
        if (w == ur) begin
          line_start = 1'b1;
          dy = 16'sd0;
        end
        #1;
        chk("lb_we", 32'(lb_we), 32'd1);
        chk("lb_addr", 32'(lb_addr), 32'(w));
        tick();
        rd_valid = 1'b0;
        if (w == ur) begin
          line_start = 1'b0;
          chk("underrun", 32'(underrun), 32'd1);
          chk("busy_at_underrun", 32'(busy), 32'd1);
        end
        for (int g = 0; g < gap; g++) begin
          tick();
          if (w == ur && g == 0) chk("underrun_end", 32'(underrun), 32'd0);
        end
        w++;
      end
      a = a + 20'(len);
      left -= len;
    end
    chk("busy_end", 32'(busy), 32'd0);
    chk("req_end", 32'(req), 32'd0);
  endtask

  initial begin
    rst_pix = 1'b1; enable = 1'b0; base_addr = 20'h0; stride = 20'd0;
    hres = 16'd0; vres = 16'sd0; dy = 16'sd0; line_start = 1'b0;
    frame_start = 1'b0; req_ack = 1'b0; rd_valid = 1'b0;
    #12;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_req_addr", 32'(req_addr), 32'd0);
    chk("rst_req_len", 32'(req_len), 32'd0);
    chk("rst_lb_we", 32'(lb_we), 32'd0);
    chk("rst_lb_addr", 32'(lb_addr), 32'd0);
    chk("rst_lb_sel", 32'(lb_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    tick();
    rst_pix = 1'b0;
    enable = 1'b1; base_addr = 20'h01000; stride = 20'd168;
    hres = 16'd672; vres = 16'sd384;
    tick();

    // Mode 3 first lines: dy=-1 -> line 0, dy=0 -> line 1.
    fs();
    chk("idle_after_fs", 32'(busy), 32'd0);
    ls(-1);
    chk("busy_start", 32'(busy), 32'd1);
    serve(20'h01000, 168, 1'b0, 2, 0, -1);
    ls(0);
    serve(20'h010A8, 168, 1'b1, 2, 0, -1);

    // base_addr changed mid-frame only takes effect at frame_start.
    base_addr = 20'h20000;
    ls(1);
    serve(20'h01150, 168, 1'b0, 2, 0, -1);
    fs();
    ls(-1);
    serve(20'h20000, 168, 1'b0, 2, 0, -1);

    // Frame end: dy=382 fetches, dy=383 and dy=-2 do not and do not advance.
    base_addr = 20'h01000;
    fs();
    ls(382);
    serve(20'h01000, 168, 1'b1, 2, 0, -1);
    ls(383);
    chk("no_fetch_383", 32'(busy), 32'd0);
    tick();
    chk("no_req_383", 32'(req), 32'd0);
    ls(-2);
    chk("no_fetch_m2", 32'(busy), 32'd0);
    ls(-1);
    serve(20'h010A8, 168, 1'b0, 2, 0, -1);

    // req_ack withheld for 50 cycles on every burst.
    fs();
    ls(-1);
    serve(20'h01000, 168, 1'b0, 50, 0, -1);

    // Throttled return overruns the line; next line_start is an underrun.
    fs();
    ls(-1);
    serve(20'h01000, 168, 1'b0, 2, 7, 20);
    ls(1);
    serve(20'h01150, 168, 1'b0, 2, 0, -1);

    // Address arithmetic wraps modulo 2^20.
    base_addr = 20'hFFF80;
    fs();
    ls(-1);
    serve(20'hFFF80, 168, 1'b0, 2, 0, -1);
    ls(0);
    serve(20'h00028, 168, 1'b1, 2, 0, -1);

    // enable drops mid-fetch: line completes, no new fetch starts.
    base_addr = 20'h01000;
    fs();
    ls(-1);
    enable = 1'b0;
    serve(20'h01000, 168, 1'b0, 2, 0, -1);
    ls(0);
    chk("disabled_no_fetch", 32'(busy), 32'd0);
    chk("disabled_no_req", 32'(req), 32'd0);
    enable = 1'b1;

    // Zero words per line (hres < 4) never leaves IDLE.
    hres = 16'd3;
    fs();
    ls(-1);
    chk("zero_wpl_busy", 32'(busy), 32'd0);
    chk("zero_wpl_req", 32'(req), 32'd0);
    hres = 16'd672;

    // Reset with 5 beats of the first burst outstanding.
    fs();
    ls(-1);
    for (int t = 0; t < 20 && req !== 1'b1; t++) tick();
    chk("rstmid_req", 32'(req), 32'd1);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    rd_valid = 1'b1;
    for (int b = 0; b < 11; b++) tick();
    chk("rstmid_lb_addr", 32'(lb_addr), 32'd11);
    rst_pix = 1'b1;
    #1;
    chk("rstmid_lb_we", 32'(lb_we), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_lb_addr0", 32'(lb_addr), 32'd0);
    chk("rstmid_req_len", 32'(req_len), 32'd0);
    chk("rstmid_req_addr", 32'(req_addr), 32'd0);
    tick();
    rst_pix = 1'b0;
    for (int b = 0; b < 5; b++) begin
      tick();
      chk("post_rst_no_we", 32'(lb_we), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    rd_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
